// File: rtl/packer_param.sv
// packer_param: gathers IN_W-bit input lanes into RATIO-lane output words.
// A word is emitted when its last slot fills or when a flush arrives with
// lanes pending; one output register sits between the packer and downstream.
module packer_param #(
    parameter int IN_W      = 8,
    parameter int RATIO     = 4,
    parameter int MSB_FIRST = 1,
    localparam int OUT_W    = IN_W * RATIO,
    localparam int LANE_W   = $clog2(RATIO + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [IN_W-1:0]   data_in,
    input  logic              flush,
    output logic              ready_in,
    output logic              valid_out,
    output logic [OUT_W-1:0]  data_out,
    output logic [LANE_W-1:0] lanes_out,
    input  logic              ready_out
);

    localparam int CNT_W = $clog2(RATIO);

    logic [OUT_W-1:0]  acc;
    logic [OUT_W-1:0]  merged;
    logic [CNT_W-1:0]  cnt;
    logic              last_slot;
    logic              lane_acc;
    logic              flush_acc;
    logic              emit;
    logic [LANE_W-1:0] lanes_held;

    // The input only stalls when a word would need the output register while
    // it is still occupied and not draining this cycle. This deliberately does
    // not look at valid_in so ready_in never depends combinationally on it.
    assign last_slot  = (cnt == CNT_W'(RATIO - 1));
    assign ready_in   = !(valid_out && !ready_out && (last_slot || flush));
    assign lane_acc   = valid_in && ready_in;
    assign flush_acc  = flush && ready_in;
    assign emit       = (lane_acc && last_slot) ||
                        (flush_acc && (valid_in || (cnt != '0)));
    assign lanes_held = LANE_W'(cnt) + LANE_W'(lane_acc);

    // Accumulator contents with this cycle's lane dropped into slot cnt.
    always_comb begin
        merged = acc;
        for (int k = 0; k < RATIO; k++) begin
            if (lane_acc && (cnt == CNT_W'(k))) begin
                if (MSB_FIRST != 0) begin
                    merged[OUT_W-1-k*IN_W -: IN_W] = data_in;
                end else begin
                    merged[k*IN_W +: IN_W] = data_in;
                end
            end
        end
    end

    // Accumulator and lane counter; both restart empty whenever a word leaves
    // so flushed words naturally carry zeros in their unused slots.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (emit) begin
            acc <= '0;
            cnt <= '0;
        end else if (lane_acc) begin
            acc <= merged;
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Output register: loading takes priority over draining so a drain and a
    // load on the same edge keep valid_out high with the new word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            lanes_out <= '0;
        end else if (emit) begin
            valid_out <= 1'b1;
            data_out  <= merged;
            lanes_out <= lanes_held;
        end else if (ready_out) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_packer_param.sv
// tb_packer_param: directed plus backpressure stimulus for two packers
// (MSB-first and LSB-first) sharing one input stream, checked by a scoreboard.
module tb_packer_param;

    localparam int IN_W  = 8;
    localparam int RATIO = 4;

    typedef struct packed {
        logic [31:0] word_m;
        logic [31:0] word_l;
        logic [2:0]  lanes;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic        flush = 1'b0;
    logic        ready_out = 1'b0;
    logic [7:0]  data_in = 8'h00;

    logic        ready_in_m, valid_out_m;
    logic [31:0] data_out_m;
    logic [2:0]  lanes_out_m;
    logic        ready_in_l, valid_out_l;
    logic [31:0] data_out_l;
    logic [2:0]  lanes_out_l;

    exp_t        exp_q[$];
    logic [7:0]  pend_q[$];
    exp_t        mon_e;
    int          compared = 0;
    int          mismatched = 0;
    bit          bp_mode = 1'b0;

    packer_param #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(1)) dut_m (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .flush(flush), .ready_in(ready_in_m), .valid_out(valid_out_m),
        .data_out(data_out_m), .lanes_out(lanes_out_m), .ready_out(ready_out)
    );

    packer_param #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(0)) dut_l (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .flush(flush), .ready_in(ready_in_l), .valid_out(valid_out_l),
        .data_out(data_out_l), .lanes_out(lanes_out_l), .ready_out(ready_out)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: collect accepted lanes, emit a word when full or flushed.
    task automatic model_accept(input logic [7:0] d, input bit is_lane, input bit is_flush);
        exp_t e;
        if (is_lane) pend_q.push_back(d);
        if ((is_flush || pend_q.size() == RATIO) && pend_q.size() > 0) begin
            e.word_m = '0;
            e.word_l = '0;
            for (int i = 0; i < pend_q.size(); i++) begin
                e.word_m[31-8*i -: 8] = pend_q[i];
                e.word_l[8*i +: 8]    = pend_q[i];
            end
            e.lanes = 3'(pend_q.size());
            exp_q.push_back(e);
            pend_q.delete();
        end
    endtask

    // Present one lane/flush (called at posedge+1), hold until accepted.
    task automatic apply_stimulus(input logic [7:0] d, input bit v, input bit f);
        bit accepted;
        accepted = 1'b0;
        valid_in = v;
        data_in  = d;
        flush    = f;
        for (int c = 0; c < 50 && !accepted; c++) begin
            if (bp_mode) ready_out = 1'($urandom_range(0, 1));
            #1;
            if (ready_in_m) begin
                model_accept(d, v, f);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        compared++;
        assert (accepted) else begin
            mismatched++;
            $error("[TB] FAIL accept_timeout: observed not accepted expected accepted data %h", d);
        end
        valid_in = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor: a word transfers on the coming edge when valid && ready.
    always @(negedge clk) begin
        if (!reset && valid_out_m && ready_out) begin
            compared++;
            assert (exp_q.size() != 0) else begin
                mismatched++;
                $error("[TB] FAIL unexpected_word: observed %h expected no word", data_out_m);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check_output("word_msb", data_out_m, mon_e.word_m);
                check_output("lanes_msb", 32'(lanes_out_m), 32'(mon_e.lanes));
                check_output("valid_lsb", 32'(valid_out_l), 32'd1);
                check_output("word_lsb", data_out_l, mon_e.word_l);
                check_output("lanes_lsb", 32'(lanes_out_l), 32'(mon_e.lanes));
            end
        end
    end

    // Directed sequence.
    initial begin
        $display("[TB] start");
        @(posedge clk);
        #1;
        check_output("rst_valid", 32'(valid_out_m), 32'd0);
        check_output("rst_data", data_out_m, 32'd0);
        check_output("rst_lanes", 32'(lanes_out_m), 32'd0);
        check_output("rst_ready_in", 32'(ready_in_m), 32'd1);
        reset     = 1'b0;
        ready_out = 1'b1;
        step(1);

        // four full lanes back to back
        apply_stimulus(8'hFF, 1, 0);
        apply_stimulus(8'hFF, 1, 0);
        apply_stimulus(8'hFF, 1, 0);
        check_output("no_early_word", 32'(valid_out_m), 32'd0);
        apply_stimulus(8'hFF, 1, 0);
        check_output("latency_valid", 32'(valid_out_m), 32'd1);
        check_output("latency_data", data_out_m, 32'hFFFFFFFF);
        step(1);

        // gaps do not disturb the accumulator
        apply_stimulus(8'hDD, 1, 0);
        step(3);
        check_output("gap_no_word", 32'(valid_out_m), 32'd0);
        apply_stimulus(8'hDD, 1, 0);
        apply_stimulus(8'hDD, 1, 0);
        apply_stimulus(8'hDD, 1, 0);
        step(1);

        // partial word via standalone flush
        apply_stimulus(8'h12, 1, 0);
        apply_stimulus(8'h34, 1, 0);
        apply_stimulus(8'h00, 0, 1);
        step(1);

        // backpressure: second word waits, lane 08 stalls
        ready_out = 1'b0;
        for (int i = 1; i <= 7; i++) apply_stimulus(8'(i), 1, 0);
        valid_in = 1'b1;
        data_in  = 8'h08;
        #1;
        check_output("blocked_ready_in", 32'(ready_in_m), 32'd0);
        step(2);
        check_output("hold_valid", 32'(valid_out_m), 32'd1);
        check_output("hold_data", data_out_m, 32'h01020304);
        check_output("hold_lanes", 32'(lanes_out_m), 32'd4);
        ready_out = 1'b1;
        #1;
        check_output("release_ready_in", 32'(ready_in_m), 32'd1);
        model_accept(8'h08, 1, 0);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        check_output("no_bubble_valid", 32'(valid_out_m), 32'd1);
        check_output("no_bubble_data", data_out_m, 32'h05060708);
        step(2);

        // reset with a pending word and a partial word
        ready_out = 1'b0;
        apply_stimulus(8'h11, 1, 0);
        apply_stimulus(8'h22, 1, 0);
        apply_stimulus(8'h33, 1, 0);
        apply_stimulus(8'h44, 1, 0);
        apply_stimulus(8'h00, 1, 0);
        apply_stimulus(8'h03, 1, 0);
        reset = 1'b1;
        #1;
        check_output("async_rst_valid", 32'(valid_out_m), 32'd0);
        check_output("async_rst_data", data_out_m, 32'd0);
        check_output("async_rst_lanes", 32'(lanes_out_m), 32'd0);
        check_output("async_rst_ready", 32'(ready_in_m), 32'd1);
        exp_q.delete();
        pend_q.delete();
        step(2);
        reset     = 1'b0;
        ready_out = 1'b1;
        step(1);
        apply_stimulus(8'hA1, 1, 0);
        apply_stimulus(8'hB2, 1, 0);
        apply_stimulus(8'hC3, 1, 0);
        apply_stimulus(8'hD4, 1, 0);
        check_output("post_rst_data", data_out_m, 32'hA1B2C3D4);
        step(1);

        // flush together with a lane, then a no-op flush
        apply_stimulus(8'h55, 1, 0);
        apply_stimulus(8'h7E, 1, 1);
        check_output("flush_lane_data", data_out_m, 32'h557E0000);
        apply_stimulus(8'h00, 0, 1);
        step(2);
        check_output("noop_flush", 32'(valid_out_m), 32'd0);

        // flush with the completing lane gives a full word
        apply_stimulus(8'h01, 1, 0);
        apply_stimulus(8'h02, 1, 0);
        apply_stimulus(8'h03, 1, 0);
        apply_stimulus(8'h04, 1, 1);
        step(1);

        // random backpressure and occasional flushes
        bp_mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(8'($urandom), 1, ($urandom_range(0, 4) == 0));
        end
        apply_stimulus(8'h00, 0, 1);
        bp_mode   = 1'b0;
        ready_out = 1'b1;

        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step(1);
        step(2);
        compared++;
        assert (exp_q.size() == 0) else begin
            mismatched++;
            $error("[TB] FAIL drain: observed %0d words left expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/packer_param.md
PACKER_PARAM -- requirements
Module: packer_param

Interface
REQ-001 Parameter IN_W, default 8, input lane width in bits (>=1).
REQ-002 Parameter RATIO, default 4, input lanes per output word (>=2); OUT_W = IN_W*RATIO.
REQ-003 Parameter MSB_FIRST, default 1; 1 = first lane into top bits, 0 = first lane into bits [IN_W-1:0].
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 valid_in  input  1  data_in carries a lane this cycle.
REQ-007 data_in  input  IN_W  input lane.
REQ-008 flush  input  1  emit the partial word now, qualified like a lane, with or without valid_in.
REQ-009 ready_in  output  1  packer accepts valid_in/flush this cycle.
REQ-010 valid_out  output  1  data_out/lanes_out hold a word.
REQ-011 data_out  output  OUT_W  packed word.
REQ-012 lanes_out  output  clog2(RATIO+1)  count of real lanes in data_out (1..RATIO).
REQ-013 ready_out  input  1  downstream accepts the word when valid_out=1.

Function
REQ-014 The block SHALL hold an accumulator (RATIO lanes), a lane counter cnt (0..RATIO-1) and one output register with valid_out flag.
REQ-015 A lane is accepted when valid_in=1 and ready_in=1; a flush is accepted when flush=1 and ready_in=1.
REQ-016 An accepted lane with cnt<RATIO-1 and no flush SHALL be written to lane slot cnt and cnt SHALL increment.
REQ-017 Slot k SHALL be bits [OUT_W-1-k*IN_W -: IN_W] when MSB_FIRST=1, bits [k*IN_W +: IN_W] when MSB_FIRST=0.
REQ-018 An accepted lane with cnt=RATIO-1 SHALL complete the word: the word moves to the output register next edge, lanes_out=RATIO, cnt returns to 0, accumulator clears.
REQ-019 An accepted flush SHALL move the word (including the lane if valid_in=1 that cycle) to the output register with unused slots zero, lanes_out = lanes held, cnt=0.
REQ-020 Flush with cnt=0 and valid_in=0 SHALL be a no-op; no word emitted.
REQ-021 Latency: word SHALL appear on valid_out the edge after the completing lane/flush is accepted.
REQ-022 The output word SHALL leave when valid_out=1 and ready_out=1; valid_out then falls unless a new word loads the same edge.
REQ-023 ready_in SHALL be 0 only when valid_out=1, ready_out=0 and the cycle would complete a word (cnt=RATIO-1 or flush); otherwise 1.
REQ-024 Simultaneous drain and load SHALL keep valid_out=1 with the new word, no bubble, no loss.
REQ-025 data_out/lanes_out SHALL stay stable while valid_out=1 and ready_out=0.
REQ-026 Lanes with valid_in=0 (gaps) SHALL not alter accumulator or cnt.
REQ-027 data_in/flush while ready_in=0 SHALL be ignored; the source holds them.

Reset
REQ-028 reset=1 SHALL immediately clear cnt, accumulator, data_out, lanes_out and valid_out to 0; ready_in reads 1.
REQ-029 Reset mid-word or with a pending output word SHALL discard both; first lane after release goes to slot 0.

Verification (IN_W=8, RATIO=4, MSB_FIRST=1 unless noted)
REQ-030 Lanes FF,FF,FF,FF back-to-back, ready_out=1 -> one cycle later valid_out=1, data_out=FFFFFFFF, lanes_out=4.
REQ-031 Lanes DD,(gap 3 cycles),DD,DD,DD -> data_out=DDDDDDDD only after 4th lane; no output during gap.
REQ-032 Lanes 12,34 then flush alone -> data_out=12340000, lanes_out=2; MSB_FIRST=0 -> 00003412.
REQ-033 ready_out=0, eight lanes 01..08 -> 01020304 held, ready_in=0 on lane 08; raise ready_out -> 05060708 follows, no loss.
REQ-034 Lanes 00,03 then reset pulse, then A1,B2,C3,D4 -> valid_out=0 during reset, output A1B2C3D4, lanes_out=4.
REQ-035 Flush with valid_in=1 data 7E at cnt=1 (prior 55) -> data_out=557E0000, lanes_out=2; flush at cnt=0, valid_in=0 -> no word.
